fetch_decode_queue: RTL

- Buffers fetched instructions between cpu_fetch and the execute/register-read stage.
- Accepts {pc, instr} beats from cpu_fetch through a valid/ready handshake and holds them in a small FIFO.
- Presents the head entry to the downstream stage, already split into fields and with a sign-extended immediate.
- Drops all buffered entries on a flush, which is asserted on a jal/jalr/taken-branch redirect.

---
 rtl/fetch_decode_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction FIFO that presents the head entry pre-split into fields.
// Optional illegal-opcode flag is enabled by defining FDQ_ILLEGAL_CHECK_EN.
module fetch_decode_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        f_valid,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  output logic        f_ready,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc_plus4,
  output logic [6:0]  d_opcode,
  output logic [4:0]  d_rd,
  output logic [2:0]  d_funct3,
  output logic [4:0]  d_rs1,
  output logic [4:0]  d_rs2,
  output logic [6:0]  d_funct7,
  output logic [31:0] d_imm,
  output logic        d_illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign f_ready = (count_q < CntW'(DEPTH));
  assign d_valid = (count_q != '0);
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= RESET_PC;
        instr_q[i] <= Nop;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_q[wr_ptr_q]    <= f_pc;
        instr_q[wr_ptr_q] <= f_instr;
      end
    end
  end

  // Stale slots may hold consumed beats, so an empty queue shows a fixed NOP.
  assign d_instr    = d_valid ? instr_q[rd_ptr_q] : Nop;
  assign d_pc       = d_valid ? pc_q[rd_ptr_q] : RESET_PC;
  assign d_pc_plus4 = d_pc + 32'd4;
  assign d_opcode   = d_instr[6:0];
  assign d_rd       = d_instr[11:7];
  assign d_funct3   = d_instr[14:12];
  assign d_rs1      = d_instr[19:15];
  assign d_rs2      = d_instr[24:20];
  assign d_funct7   = d_instr[31:25];

  always_comb begin
    d_imm = '0;
    case (d_opcode)
      7'b0000011, 7'b0010011, 7'b1100111: d_imm = {{20{d_instr[31]}}, d_instr[31:20]};
      7'b0100011: d_imm = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
      7'b1100011: d_imm = {{19{d_instr[31]}}, d_instr[31], d_instr[7], d_instr[30:25],
                           d_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111: d_imm = {d_instr[31:12], 12'b0};
      7'b1101111: d_imm = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12], d_instr[20],
                           d_instr[30:21], 1'b0};
      default: d_imm = '0;
    endcase
  end

`ifdef FDQ_ILLEGAL_CHECK_EN
  logic legal_op;

  always_comb begin
    legal_op = 1'b0;
    case (d_opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  assign d_illegal = d_valid & ((d_instr[1:0] != 2'b11) | ~legal_op);
`else
  assign d_illegal = 1'b0;
`endif

endmodule
